// File: rtl/mdu_ctrl_pkg.sv
// Shared types and constants for the iterative multiply/divide sequencer.
// Holds the operation encoding, FSM state encoding, iteration counts and a
// small helper for sign-extending 32-bit word results.
package mdu_ctrl_pkg;

  localparam int MDU_ITER64 = 64;
  localparam int MDU_ITER32 = 32;

  typedef enum logic [2:0] {
    MDU_MUL  = 3'd0,
    MDU_DIV  = 3'd1,
    MDU_DIVU = 3'd2,
    MDU_REM  = 3'd3,
    MDU_REMU = 3'd4
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mdu_state_t;

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/mdu_ctrl_step.sv
// One combinational iteration of the shared datapath: shift-add for multiply,
// restoring shift-subtract for divide. Latency: 0 cycles (pure logic).
// Backpressure: none; the owner decides when to register the outputs.
// Ports: is_div selects the divide step; acc/opa/opb are the current
// accumulator, multiplicand-or-divisor, and multiplier-or-quotient registers.
module mdu_step (
  input  logic        is_div,
  input  logic [63:0] acc,
  input  logic [63:0] opa,
  input  logic [63:0] opb,
  output logic [63:0] acc_nxt,
  output logic [63:0] opa_nxt,
  output logic [63:0] opb_nxt
);

  logic [64:0] shifted;
  logic [64:0] trial;

  always_comb begin
    acc_nxt = acc;
    opa_nxt = opa;
    opb_nxt = opb;
    // Partial remainder is at most 65 bits after the shift, so the trial
    // subtraction is done one bit wider and its MSB is the borrow.
    shifted = {acc, opb[63]};
    trial   = shifted - {1'b0, opa};
    if (is_div) begin
      if (!trial[64]) begin
        acc_nxt = trial[63:0];
        opb_nxt = {opb[62:0], 1'b1};
      end else begin
        acc_nxt = shifted[63:0];
        opb_nxt = {opb[62:0], 1'b0};
      end
    end else begin
      if (opb[0]) begin
        acc_nxt = acc + opa;
      end
      opa_nxt = opa << 1;
      opb_nxt = opb >> 1;
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// RV64M multiply/divide sequencer: one op at a time over a shared iterative datapath.
// Latency: N+2 edges from accept to done (N=64, or 32 for word ops); 1 edge for div-by-zero/overflow.
// Backpressure: result held with done=1 until ack; a new op may be accepted in the ack cycle; flush aborts.
// Ports: clk/reset (async active-low); start/op/word/a/b request; flush abort;
// ack result consumed; busy (CALC/FIX), done (DONE), result (registered).
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic            word,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  input  logic            ack,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  mdu_state_t state_q, state_d;
  mdu_op_t    op_q, op_d;
  logic       word_q, word_d;
  logic       sa_q, sa_d;
  logic       sb_q, sb_d;
  logic [5:0] cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [63:0] opa_q, opa_d;
  logic [63:0] opb_q, opb_d;
  logic [63:0] result_q, result_d;

  // Operand preparation for the incoming request.
  mdu_op_t     op_in;
  logic        signed_in, is_div_in;
  logic [63:0] a_ext, b_ext, mag_a, mag_b, min_neg, fast_res;
  logic        neg_a, neg_b, b_zero, ovf, fast, accept;

  always_comb begin
    op_in     = mdu_op_t'(op);
    signed_in = (op_in == MDU_DIV) || (op_in == MDU_REM);
    is_div_in = (op_in != MDU_MUL);
    if (word) begin
      a_ext   = signed_in ? sext32(a[31:0]) : {32'b0, a[31:0]};
      b_ext   = signed_in ? sext32(b[31:0]) : {32'b0, b[31:0]};
      min_neg = 64'hFFFF_FFFF_8000_0000;
    end else begin
      a_ext   = a;
      b_ext   = b;
      min_neg = 64'h8000_0000_0000_0000;
    end
    neg_a  = signed_in && a_ext[63];
    neg_b  = signed_in && b_ext[63];
    mag_a  = neg_a ? -a_ext : a_ext;
    mag_b  = neg_b ? -b_ext : b_ext;
    b_zero = is_div_in && (b_ext == 64'd0);
    ovf    = signed_in && (a_ext == min_neg) && (b_ext == '1);
    fast   = b_zero || ovf;
    if (b_zero) begin
      if ((op_in == MDU_DIV) || (op_in == MDU_DIVU)) begin
        fast_res = '1;
      end else begin
        fast_res = word ? sext32(a_ext[31:0]) : a_ext;
      end
    end else begin
      fast_res = (op_in == MDU_DIV) ? min_neg : 64'd0;
    end
    accept = start && !flush && ((state_q == IDLE) || ((state_q == DONE) && ack));
  end

  // Datapath step.
  logic [63:0] step_acc, step_opa, step_opb;

  mdu_step u_step (
    .is_div  (op_q != MDU_MUL),
    .acc     (acc_q),
    .opa     (opa_q),
    .opb     (opb_q),
    .acc_nxt (step_acc),
    .opa_nxt (step_opa),
    .opb_nxt (step_opb)
  );

  // Sign fix-up and output selection. Divides ran on magnitudes; for word
  // ops the quotient ends in opb[31:0] because the dividend was loaded high.
  logic [63:0] fix_raw, fix_res;

  always_comb begin
    case (op_q)
      MDU_DIV:  fix_raw = (sa_q ^ sb_q) ? -opb_q : opb_q;
      MDU_DIVU: fix_raw = opb_q;
      MDU_REM:  fix_raw = sa_q ? -acc_q : acc_q;
      default:  fix_raw = acc_q;
    endcase
    fix_res = word_q ? sext32(fix_raw[31:0]) : fix_raw;
  end

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    word_d   = word_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = 6'd0;
    end else if (accept) begin
      op_d   = op_in;
      word_d = word;
      sa_d   = neg_a;
      sb_d   = neg_b;
      if (is_div_in && fast) begin
        state_d  = DONE;
        result_d = fast_res;
      end else begin
        state_d = CALC;
        cnt_d   = word ? 6'(MDU_ITER32 - 1) : 6'(MDU_ITER64 - 1);
        acc_d   = 64'd0;
        if (op_in == MDU_MUL) begin
          opa_d = a_ext;
          opb_d = b_ext;
        end else begin
          opa_d = mag_b;
          // Word dividends start in the top half so 32 shifts walk every bit.
          opb_d = word ? {mag_a[31:0], 32'b0} : mag_a;
        end
      end
    end else begin
      case (state_q)
        CALC: begin
          acc_d = step_acc;
          opa_d = step_opa;
          opb_d = step_opb;
          if (cnt_q == 6'd0) begin
            state_d = FIX;
          end else begin
            cnt_d = cnt_q - 6'd1;
          end
        end
        FIX: begin
          result_d = fix_res;
          state_d  = DONE;
        end
        DONE: begin
          if (ack) begin
            state_d = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      op_q     <= MDU_MUL;
      word_q   <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      cnt_q    <= 6'd0;
      acc_q    <= 64'd0;
      opa_q    <= 64'd0;
      opb_q    <= 64'd0;
      result_q <= 64'd0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      word_q   <= word_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == CALC) || (state_q == FIX);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Iterative multiply/divide sequencer for the execute stage. It accepts one RV64M operation from execute and runs it on a shared shift-add/shift-subtract datapath. It signals completion to execute, which drives its `data_ok` stall output from `done`. Divide-by-zero and signed-overflow cases use a one-cycle fast path, and a pipeline flush can abort an operation at any point.

## Interface
Parameters:
- XLEN, 64, operand/result width (fixed; word ops use low 32 bits)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset; 0 forces all state to reset values immediately
- start  in  1  request; sampled only when accepting (see Operation)
- op  in  3  mdu_op_t: MDU_MUL, MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU
- word  in  1  1 = *W variant (32-bit operands, sign-extended 32-bit result)
- a  in  64  rs1 value (already forwarded)
- b  in  64  rs2 value (already forwarded)
- flush  in  1  abort current op, return to IDLE
- ack  in  1  execute has consumed result (stage advances)
- busy  out  1  op in progress (state CALC or FIX)
- done  out  1  result valid (state DONE)
- result  out  64  final value; stable while done=1

## Operation
- States: IDLE, CALC, FIX, DONE (mdu_state_t).
- Accept condition: start=1 && flush=0 && (state==IDLE || (state==DONE && ack=1)). On accept:
  - latch op and word;
  - prepare operands: word=1 → a,b taken from [31:0], sign-extended for signed ops and zero-extended for unsigned ops;
  - signed div/rem → latch operand magnitudes and sign flags.
- Fast path on accept, next state DONE, result computed directly:
  - b==0 for any div/rem: DIV/DIVU → all ones; REM/REMU → dividend (after extension).
  - Signed overflow: DIV with dividend == most-negative and b == -1 (64- or 32-bit as per word) → quotient = most-negative; REM → 0.
- Normal path: next state CALC. Iteration counter loads N-1, with N=64 (word=0) or 32 (word=1).
- CALC performs one step per cycle:
  - MUL: if multiplier LSB is 1, add multiplicand to product; shift multiplicand left and multiplier right.
  - Div: restoring step — shift {rem,quot} left by 1, trial-subtract divisor, set quotient bit if the remainder is non-negative.
  - Counter==0 → FIX.
- FIX: apply signs, then select the output.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - word=1 → result = sign-extend of bits [31:0] (also for DIVU/REMU/MUL).
  - Result is registered, then state goes to DONE.
- DONE: hold done=1 and result stable until ack. If ack=1 and there is no new accept → IDLE; if ack=1 with an accept → new op.
- flush=1 in any state → IDLE next cycle and internal registers are discarded. flush has priority over start and ack.
- start outside the accept condition is ignored; no queuing.
- MUL returns the low 64 bits, so signedness does not matter.

## Timing
- Reset values: state=IDLE, busy=0, done=0, result=0, counter=0.
- done and busy are decoded from registered state; result is a register. No combinational path from inputs to outputs.
- Latency from the accept edge to done=1:
  - N+2 cycles: 66 for 64-bit, 34 for word ops;
  - 1 cycle on the fast path.
- Back-to-back throughput: a new accept is possible in the same cycle as ack.
- Reset asserted mid-operation returns to IDLE asynchronously; no partial result is visible.

## Structure
- Shared package (pipes) holds:
  - mdu_op_t and its encodings;
  - mdu_state_t;
  - constant MDU_ITER64=64 and MDU_ITER32=32.
- Execute's alu instantiates mdu_ctrl for M-extension funcs and muxes `result`. `done` feeds execute's data_ok.
- One sub-module is natural: mdu_step, a combinational single iteration (add-shift / subtract-shift) over {acc, operand} registers owned by mdu_ctrl.
- The FSM, counter, sign fix-up and fast path stay in mdu_ctrl.

## Test plan
- MUL a=7, b=-3 (64-bit) → done after 66 cycles, result=0xFFFFFFFFFFFFFFEB; busy=1 for cycles 1–65; ack returns to IDLE.
- DIVW a=0x00000000FFFFFFF9 (-7), b=2 → result=0xFFFFFFFFFFFFFFFD (-3) after 34 cycles. REMW with the same operands → 0xFFFFFFFFFFFFFFFF (-1).
- Fast path cases, each with done after 1 cycle:
  - DIVU a=5, b=0 → all ones.
  - REM a=5, b=0 → 5.
  - DIV a=0x8000000000000000, b=-1 → 0x8000000000000000.
- Flush at cycle 10 of a DIV → IDLE next cycle, done never asserts. A new start immediately afterwards (REMU 10,3 → 1) completes correctly.
- Hold ack=0 for 5 cycles in DONE → done and result stay constant. Then ack=1 with start=1 (MUL 3,4) → next result 12, with no idle cycle in between.
- reset=0 during CALC → busy=0, done=0, result=0 immediately. start during CALC is ignored and the result is unaffected.
